// File: rtl/pc_fetch_ctrl_if.sv
// Instruction-memory request bus between the fetch controller and imem.
// Signal names are from the controller's point of view.
interface pc_fetch_ctrl_if #(
  parameter int unsigned XLEN = 32
);
  logic            o_req;
  logic [XLEN-1:0] o_req_addr;
  logic            i_gnt;
  logic            i_rvalid;

  modport master (
    output o_req,
    output o_req_addr,
    input  i_gnt,
    input  i_rvalid
  );

  modport slave (
    input  o_req,
    input  o_req_addr,
    output i_gnt,
    output i_rvalid
  );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// Fetch PC and in-order imem request controller with redirect squashing.
// Optional PC_ALIGN_CHECK_EN: sticky misaligned-redirect flag that holds fetch.
module pc_fetch_ctrl #(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = 'h80,
  parameter int unsigned     MAX_OUTST = 2,
  parameter int unsigned     INSTR_B   = 4
) (
  input  logic              i_clk,
  input  logic              i_resetn,
  input  logic              i_stall,
  input  logic              i_redirect,
  input  logic [XLEN-1:0]   i_redirect_pc,
  pc_fetch_ctrl_if.master   bus,
  output logic [XLEN-1:0]   o_pc,
  output logic              o_pc_valid,
  output logic              o_busy,
  output logic              o_misalign
);

  localparam int CW = $clog2(MAX_OUTST + 1);
  localparam int PW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam logic [CW-1:0]   MAXC  = CW'(MAX_OUTST);
  localparam logic [PW-1:0]   LASTP = PW'(MAX_OUTST - 1);
  localparam logic [XLEN-1:0] STEP  = XLEN'(INSTR_B);

  typedef enum logic [1:0] {
    S_BOOT,
    S_RUN,
    S_FLUSH
  } state_t;

  state_t          r_state;
  state_t          w_state_n;
  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] r_fifo [MAX_OUTST];
  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic [CW-1:0]   r_outst;
  logic [CW-1:0]   r_squash;
  logic [CW-1:0]   w_squash_n;
  logic            w_acc;
  logic            w_rsp;
  logic            w_live;
  logic            w_mis_n;

  assign bus.o_req = (r_state == S_RUN) & ~i_stall &
                     ~i_redirect & (r_outst < MAXC);
  assign bus.o_req_addr = r_fetch_pc;

  assign w_acc  = bus.o_req & bus.i_gnt;
  assign w_rsp  = bus.i_rvalid & (r_outst != '0);
  assign w_live = w_rsp & (r_squash == '0);
  assign o_busy = (r_outst != '0);

`ifdef PC_ALIGN_CHECK_EN
  localparam logic [XLEN-1:0] AMASK = XLEN'(INSTR_B - 1);
  logic r_misalign;

  assign w_mis_n = i_redirect ? |(i_redirect_pc & AMASK)
                              : r_misalign;
  assign o_misalign = r_misalign;

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) r_misalign <= 1'b0;
    else           r_misalign <= w_mis_n;
  end
`else
  assign w_mis_n    = 1'b0;
  assign o_misalign = 1'b0;
`endif

  // In FLUSH squash always equals outst, so one formula covers both states.
  always_comb begin
    w_squash_n = r_squash;
    if (i_redirect)
      w_squash_n = r_outst - CW'(w_rsp);
    else if (w_rsp && (r_squash != '0))
      w_squash_n = r_squash - CW'(1);
  end

  always_comb begin
    w_state_n = r_state;
    unique case (r_state)
      S_RUN: begin
        if (i_redirect && ((w_squash_n != '0) || w_mis_n))
          w_state_n = S_FLUSH;
      end
      S_BOOT, S_FLUSH: begin
        if ((w_squash_n == '0) && !w_mis_n)
          w_state_n = S_RUN;
        else
          w_state_n = S_FLUSH;
      end
      default: w_state_n = S_BOOT;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_state    <= S_BOOT;
      r_fetch_pc <= RESET_PC;
      r_outst    <= '0;
      r_squash   <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      o_pc       <= RESET_PC;
      o_pc_valid <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_squash   <= w_squash_n;
      r_outst    <= r_outst + CW'(w_acc) - CW'(w_rsp);
      o_pc_valid <= w_live;
      if (i_redirect)
        r_fetch_pc <= i_redirect_pc;
      else if (w_acc)
        r_fetch_pc <= r_fetch_pc + STEP;
      if (w_acc)
        r_wptr <= (r_wptr == LASTP) ? '0 : r_wptr + 1'b1;
      if (w_rsp)
        r_rptr <= (r_rptr == LASTP) ? '0 : r_rptr + 1'b1;
      if (w_live)
        o_pc <= r_fifo[r_rptr];
    end
  end

  // Tag storage needs no reset: pointers define which entries are live.
  always_ff @(posedge i_clk) begin
    if (w_acc)
      r_fifo[r_wptr] <= r_fetch_pc;
  end

endmodule
